vga_mem_read_responder: RTL and testbench
=========================================

// Module: vga_mem_read_responder
// PURPOSE
//  Memory-side responder for the VGA pixel-request interface: services each vga_flag
//  request from the VGA write FIFO by reading one 36-bit word (2 x 18-bit pixels) from
//  the ZBT frame buffer at the (hcount,vcount) location, returning it on pixel with a
//  done_vga pulse. Double-buffered: frame_flag requests a buffer swap, applied in vblank.
// PARAMETERS
//  H_ACTIVE     640      active pixels per line
//  V_ACTIVE     480      active lines per frame
//  WORDS_LINE   320      36-bit words per line (H_ACTIVE/2)
//  READ_LAT     2        ZBT read latency in clock cycles, address-to-data (>=1)
//  BUF0_BASE    19'h00000 word base address, frame buffer 0
//  BUF1_BASE    19'h40000 word base address, frame buffer 1
// PORTS
//  clock        in   1   system clock; all logic on posedge
//  reset_b      in   1   asynchronous, active-low reset
//  vga_flag     in   1   pixel-word request; level, held until done_vga
//  hcount       in   10  pixel column of requested word (bit 0 ignored)
//  vcount       in   10  line of requested word
//  frame_flag   in   1   one-cycle pulse: writer finished a frame, swap buffers
//  mem_busy     in   1   another client owns the ZBT this cycle; do not issue
//  mem_rdata    in   36  ZBT read data, valid READ_LAT cycles after address
//  mem_addr     out  19  ZBT word address
//  mem_oe_b     out  1   ZBT read enable, active-low, one cycle per read
//  done_vga     out  1   one-cycle pulse: pixel holds the requested word
//  pixel        out  36  returned word {pix_even[17:0], pix_odd[17:0]}
//  disp_buf     out  1   buffer currently displayed (0/1)
// BEHAVIOUR
//  Reset (async, reset_b=0): state IDLE, mem_addr=0, mem_oe_b=1, done_vga=0, pixel=0,
//   disp_buf=0, swap_pending=0, in-flight read discarded. Release is sync to clock.
//  Address: base + vcount*320 + hcount[9:1], with vcount*320=(vcount<<8)+(vcount<<6);
//   19-bit unsigned, no wrap expected; base=disp_buf?BUF1_BASE:BUF0_BASE.
//  FSM IDLE->ISSUE->WAIT(READ_LAT-1 cycles)->CAPTURE->DONE->IDLE:
//   IDLE: vga_flag=1 & mem_busy=0 -> latch hcount/vcount, ISSUE; mem_busy=1 -> stay.
//   ISSUE: drive mem_addr, mem_oe_b=0 for exactly 1 cycle.
//   CAPTURE: pixel<=mem_rdata exactly READ_LAT cycles after ISSUE.
//   DONE: done_vga=1 for 1 cycle; pixel stable until next CAPTURE.
//  Latency vga_flag->done_vga with mem_busy=0: READ_LAT+2 cycles (4 at default).
//  vga_flag must drop the cycle after done_vga; IDLE always spends >=1 cycle, so a
//   held-high vga_flag yields one transfer per READ_LAT+3 cycles, never a double.
//  mem_busy is sampled only in IDLE; once ISSUE is entered the read completes.
//  Swap: frame_flag sets swap_pending (extra pulses while pending: no effect). Applied
//   in IDLE when vcount>=V_ACTIVE: disp_buf toggles, swap_pending clears. Never mid-read.
//  frame_flag same cycle as applied swap: pending re-set, applied at next vblank.
//  Request with vcount>=V_ACTIVE or hcount>=H_ACTIVE: serviced normally (no check).
// CONFIGURATION
//  VGA_RD_PATTERN_EN defined: input pattern_sel (1 bit) added. pattern_sel=1 at request
//   accept -> no ZBT access (mem_oe_b stays 1), pixel={16'd0,vcount,hcount}, same
//   latency and done_vga timing. Undefined: port absent, all requests read ZBT.
// TESTING
//  1 reset_b=0 mid-WAIT -> done_vga never pulses, mem_oe_b=1, pixel=0, disp_buf=0.
//  2 vga_flag at h=4,v=1, rdata model returns addr -> mem_addr=19'h00142, done_vga
//    4 cycles after vga_flag, pixel=36'h00142.
//  3 mem_busy=1 for 5 cycles during request -> no mem_oe_b low until busy drops;
//    done_vga 4 cycles after busy deasserts; exactly one done_vga.
//  4 frame_flag at v=100, request at v=480 then v=0,h=0 -> disp_buf=1 after vblank
//    request; next read mem_addr=19'h40000.
//  5 vga_flag held high 3 transfers -> done_vga pulses spaced 5 cycles, no duplicates.
//  6 VGA_RD_PATTERN_EN, pattern_sel=1, h=10,v=3 -> pixel=36'h00000_0C0A, mem_oe_b=1.

Source files
------------

// File: rtl/vga_mem_read_responder.sv
// vga_mem_read_responder: serves VGA pixel-word requests from a
// double-buffered ZBT frame buffer, one 36-bit word per request.
// Ports: clock, reset_b (async low); vga_flag/hcount/vcount request;
//  frame_flag swap request; mem_busy/mem_rdata from ZBT;
//  mem_addr/mem_oe_b to ZBT; done_vga/pixel reply; disp_buf shown.
// Option VGA_RD_PATTERN_EN adds pattern_sel: a request accepted with
//  pattern_sel=1 returns {16'd0,vcount,hcount} without touching the ZBT.
module vga_mem_read_responder #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int WORDS_LINE = H_ACTIVE / 2,
  parameter int READ_LAT = 2,
  parameter logic [18:0] BUF0_BASE = 19'h00000,
  parameter logic [18:0] BUF1_BASE = 19'h40000
) (
  input  logic        clock,
  input  logic        reset_b,
  input  logic        vga_flag,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  input  logic        frame_flag,
  input  logic        mem_busy,
  input  logic [35:0] mem_rdata,
`ifdef VGA_RD_PATTERN_EN
  input  logic        pattern_sel,
`endif
  output logic [18:0] mem_addr,
  output logic        mem_oe_b,
  output logic        done_vga,
  output logic [35:0] pixel,
  output logic        disp_buf
);

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT, CAPTURE, DONE
  } state_t;

  localparam int CW = (READ_LAT > 2) ? $clog2(READ_LAT) : 1;
  localparam int WL = (READ_LAT > 1) ? READ_LAT - 2 : 0;
  localparam logic [CW-1:0] WLAST = CW'(WL);

  state_t state;
  state_t state_nx;
  logic [CW-1:0] wcnt;
  logic swap_pending;
  logic accept;
  logic swap_now;
  logic [18:0] base;
  logic [18:0] addr_nx;
  logic unused;

`ifdef VGA_RD_PATTERN_EN
  logic pat_q;
  logic [9:0] h_q;
  logic [9:0] v_q;
`endif

  assign unused = hcount[0];

  assign base = disp_buf ? BUF1_BASE : BUF0_BASE;
  assign addr_nx = base
                 + 19'(vcount) * 19'(WORDS_LINE)
                 + {10'd0, hcount[9:1]};

  always_comb begin
    state_nx = state;
    accept = 1'b0;
    swap_now = 1'b0;
    case (state)
      IDLE: begin
        swap_now = swap_pending
                 && (vcount >= 10'(V_ACTIVE));
        if (vga_flag && !mem_busy) begin
          accept = 1'b1;
          state_nx = ISSUE;
        end
      end
      ISSUE: begin
        state_nx = (READ_LAT > 1) ? WAIT : CAPTURE;
      end
      WAIT: begin
        if (wcnt == WLAST) state_nx = CAPTURE;
      end
      CAPTURE: state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      mem_addr <= '0;
      wcnt <= '0;
      pixel <= '0;
      disp_buf <= 1'b0;
      swap_pending <= 1'b0;
`ifdef VGA_RD_PATTERN_EN
      pat_q <= 1'b0;
      h_q <= '0;
      v_q <= '0;
`endif
    end else begin
      if (accept) begin
        mem_addr <= addr_nx;
`ifdef VGA_RD_PATTERN_EN
        pat_q <= pattern_sel;
        h_q <= hcount;
        v_q <= vcount;
`endif
      end
      if (state == ISSUE) begin
        wcnt <= '0;
      end else if (state == WAIT) begin
        wcnt <= wcnt + 1'b1;
      end
      if (state == CAPTURE) begin
`ifdef VGA_RD_PATTERN_EN
        pixel <= pat_q ? {16'd0, v_q, h_q}
                       : mem_rdata;
`else
        pixel <= mem_rdata;
`endif
      end
      // A frame_flag landing on the swap cycle arms the next swap.
      if (swap_now) begin
        disp_buf <= ~disp_buf;
        swap_pending <= frame_flag;
      end else if (frame_flag) begin
        swap_pending <= 1'b1;
      end
    end
  end

`ifdef VGA_RD_PATTERN_EN
  assign mem_oe_b = !(state == ISSUE) || pat_q;
`else
  assign mem_oe_b = !(state == ISSUE);
`endif
  assign done_vga = (state == DONE);

endmodule

// File: tb/tb_vga_mem_read_responder.sv
// tb_vga_mem_read_responder: scoreboard bench with a ZBT latency
// model and a frame-buffer address/swap reference model.
module tb_vga_mem_read_responder;
  localparam int RL = 2;

  logic clock = 1'b0;
  logic reset_b = 1'b0;
  logic vga_flag = 1'b0;
  logic [9:0] hcount = '0;
  logic [9:0] vcount = '0;
  logic frame_flag = 1'b0;
  logic mem_busy = 1'b0;
  logic [35:0] mem_rdata;
  logic [18:0] mem_addr;
  logic mem_oe_b;
  logic done_vga;
  logic [35:0] pixel;
  logic disp_buf;
`ifdef VGA_RD_PATTERN_EN
  logic pattern_sel = 1'b0;
`endif

  always #5 clock = ~clock;

  vga_mem_read_responder dut (
    .clock(clock),
    .reset_b(reset_b),
    .vga_flag(vga_flag),
    .hcount(hcount),
    .vcount(vcount),
    .frame_flag(frame_flag),
    .mem_busy(mem_busy),
    .mem_rdata(mem_rdata),
`ifdef VGA_RD_PATTERN_EN
    .pattern_sel(pattern_sel),
`endif
    .mem_addr(mem_addr),
    .mem_oe_b(mem_oe_b),
    .done_vga(done_vga),
    .pixel(pixel),
    .disp_buf(disp_buf)
  );

  function automatic logic [35:0] zbt_word(input logic [18:0] a);
    return {a[16:0] ^ 17'h1A5A5, a};
  endfunction

  // ZBT model: data appears RL cycles after a sampled read; junk otherwise.
  logic [35:0] pipe [RL];
  always @(posedge clock) begin
    if (!mem_oe_b) pipe[0] <= zbt_word(mem_addr);
    else pipe[0] <= 36'({$urandom(), $urandom()});
    for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_rdata = pipe[RL-1];

  int checks = 0;
  int errors = 0;
  int oe_cnt = 0;
  int done_cnt = 0;
  int mdisp = 0;
  int mpend = 0;
  logic [18:0] exp_addr_q [$];
  logic [35:0] exp_pix_q [$];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bad(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got event expected none", name);
  endtask

  always @(negedge clock) begin
    if (reset_b) begin
      if (!mem_oe_b) begin
        oe_cnt++;
        if (exp_addr_q.size() == 0) bad("unexpected_read");
        else chk("mem_addr", 64'(mem_addr), 64'(exp_addr_q.pop_front()));
      end
      if (done_vga) begin
        done_cnt++;
        if (exp_pix_q.size() == 0) bad("unexpected_done");
        else chk("pixel", 64'(pixel), 64'(exp_pix_q.pop_front()));
      end
    end
  end

  function automatic logic [18:0] addr_of(input int h, input int v);
    int base;
    base = (mdisp != 0) ? 32'h40000 : 0;
    return 19'(base + v * 320 + h / 2);
  endfunction

  // One idle-state cycle with new coordinates; swap model applied here.
  task automatic idle_cycle(input int h, input int v, input bit ff);
    hcount = 10'(h);
    vcount = 10'(v);
    frame_flag = ff;
    if (v >= 480 && mpend != 0) begin
      mdisp = 1 - mdisp;
      mpend = 0;
    end
    if (ff) mpend = 1;
    @(negedge clock);
    frame_flag = 1'b0;
    chk("disp_buf", 64'(disp_buf), 64'(mdisp));
  endtask

  task automatic push_exp(input int h, input int v, input bit pat);
    logic [18:0] a;
    logic [9:0] hh;
    logic [9:0] vv;
    hh = 10'(h);
    vv = 10'(v);
    if (pat) begin
      exp_pix_q.push_back({16'd0, vv, hh});
    end else begin
      a = addr_of(h, v);
      exp_addr_q.push_back(a);
      exp_pix_q.push_back(zbt_word(a));
    end
  endtask

  task automatic request(input int h, input int v, input bit ff,
                         input int nbusy, input bit pat);
    int lat;
    bit got;
    idle_cycle(h, v, ff);
    push_exp(h, v, pat);
    oe_cnt = 0;
`ifdef VGA_RD_PATTERN_EN
    pattern_sel = pat;
`endif
    vga_flag = 1'b1;
    mem_busy = (nbusy > 0);
    lat = 0;
    got = 1'b0;
    while (lat < 40 && !got) begin
      @(negedge clock);
      lat++;
      if (lat == nbusy) mem_busy = 1'b0;
      if (done_vga) got = 1'b1;
    end
    mem_busy = 1'b0;
    vga_flag = 1'b0;
`ifdef VGA_RD_PATTERN_EN
    pattern_sel = 1'b0;
`endif
    chk("latency", 64'(lat), 64'(nbusy + 4));
    chk("oe_cycles", 64'(oe_cnt), pat ? 64'd0 : 64'd1);
    @(negedge clock);
  endtask

  initial begin
    int t [3];
    int n;
    int k;
    int dc0;
    int h;
    int v;
    bit ff;
    int nb;
    bit pat;

    repeat (2) @(negedge clock);
    chk("rst_oe", 64'(mem_oe_b), 64'd1);
    chk("rst_done", 64'(done_vga), 64'd0);
    chk("rst_pixel", 64'(pixel), 64'd0);
    chk("rst_addr", 64'(mem_addr), 64'd0);
    chk("rst_disp", 64'(disp_buf), 64'd0);
    reset_b = 1'b1;
    @(negedge clock);

    request(4, 1, 1'b0, 0, 1'b0);
    chk("t2_addr", 64'(mem_addr), 64'h142);
    chk("t2_pixel", 64'(pixel), 64'(zbt_word(19'h142)));

    request(8, 2, 1'b0, 5, 1'b0);

    idle_cycle(0, 100, 1'b1);
    request(0, 480, 1'b0, 0, 1'b0);
    chk("t4_disp", 64'(disp_buf), 64'd1);
    request(0, 0, 1'b0, 0, 1'b0);
    chk("t4_addr", 64'(mem_addr), 64'h40000);

    idle_cycle(0, 10, 1'b1);
    idle_cycle(0, 480, 1'b1);
    idle_cycle(0, 0, 1'b0);
    idle_cycle(0, 481, 1'b0);
    request(100, 481, 1'b0, 0, 1'b0);

    idle_cycle(20, 7, 1'b0);
    for (int i = 0; i < 3; i++) push_exp(20, 7, 1'b0);
    oe_cnt = 0;
    vga_flag = 1'b1;
    n = 0;
    k = 0;
    while (k < 60 && n < 3) begin
      @(negedge clock);
      k++;
      if (done_vga) begin
        t[n] = k;
        n++;
      end
    end
    vga_flag = 1'b0;
    chk("t5_count", 64'(n), 64'd3);
    if (n == 3) begin
      chk("t5_first", 64'(t[0]), 64'd4);
      chk("t5_gap1", 64'(t[1] - t[0]), 64'd5);
      chk("t5_gap2", 64'(t[2] - t[1]), 64'd5);
    end
    chk("t5_oe", 64'(oe_cnt), 64'd3);
    @(negedge clock);

`ifdef VGA_RD_PATTERN_EN
    request(10, 3, 1'b0, 0, 1'b1);
    chk("t6_pixel", 64'(pixel), 64'h0_0000_0C0A);
`endif

    for (int i = 0; i < 60; i++) begin
      h = int'($urandom_range(0, 639));
      if ($urandom_range(0, 4) == 0) v = int'($urandom_range(480, 524));
      else v = int'($urandom_range(0, 479));
      ff = (v < 480) && ($urandom_range(0, 5) == 0);
      nb = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
      pat = 1'b0;
`ifdef VGA_RD_PATTERN_EN
      pat = ($urandom_range(0, 3) == 0);
`endif
      request(h, v, ff, nb, pat);
    end

    idle_cycle(0, 300, 1'b1);
    idle_cycle(0, 500, 1'b0);
    idle_cycle(6, 20, 1'b0);
    push_exp(6, 20, 1'b0);
    vga_flag = 1'b1;
    @(negedge clock);
    @(negedge clock);
    #2 reset_b = 1'b0;
    #1;
    chk("t1_done", 64'(done_vga), 64'd0);
    chk("t1_oe", 64'(mem_oe_b), 64'd1);
    chk("t1_pixel", 64'(pixel), 64'd0);
    chk("t1_disp", 64'(disp_buf), 64'd0);
    vga_flag = 1'b0;
    exp_pix_q.delete();
    exp_addr_q.delete();
    mdisp = 0;
    mpend = 0;
    @(negedge clock);
    @(negedge clock);
    reset_b = 1'b1;
    dc0 = done_cnt;
    repeat (8) @(negedge clock);
    chk("t1_no_done", 64'(done_cnt - dc0), 64'd0);
    request(40, 12, 1'b0, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
